// File: rtl/uart_pkg.sv
// Shared UART-side types: the response packet handed to the serializer
// and the state encoding of the transmit arbiter.
package uart_pkg;

  typedef struct packed {
    logic [7:0] cmd_type;
    logic [7:0] addr;
    logic [7:0] data;
  } cmd_packet_t;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_PRESENT,
    ARB_DRAIN
  } arb_state_e;

  // Index width for n requesters, never narrower than one bit.
  function automatic int idWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or above the pointer,
// wrapping modulo NUM_REQ. Reusable wherever a rotating priority is needed.
module rr_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 2,
  localparam int IDW = idWidth(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [IDW-1:0]     rr_ptr,
  output logic [NUM_REQ-1:0] gnt_onehot,
  output logic [IDW-1:0]     gnt_idx,
  output logic               gnt_any
);

  logic [IDW:0]   w_sum;
  logic [IDW-1:0] w_pos;

  // One extra bit on the sum keeps ptr+k from overflowing before the wrap.
  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    gnt_any    = 1'b0;
    w_sum      = '0;
    w_pos      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_sum = {1'b0, rr_ptr} + (IDW+1)'(k);
      if (w_sum >= (IDW+1)'(NUM_REQ)) begin
        w_sum = w_sum - (IDW+1)'(NUM_REQ);
      end
      w_pos = w_sum[IDW-1:0];
      if (!gnt_any && req_valid[w_pos]) begin
        gnt_any           = 1'b1;
        gnt_onehot[w_pos] = 1'b1;
        gnt_idx           = w_pos;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Shares one uart_tx serializer between NUM_REQ producers: grants one packet,
// presents it until popped, waits out the frame, and aborts stuck packets.
module uart_tx_arb
  import uart_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int TIMEOUT_CYC = 100000,
  localparam int IDW = idWidth(NUM_REQ)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  cmd_packet_t [NUM_REQ-1:0]  req_pkt,
  output logic [NUM_REQ-1:0]         req_ready,
  output cmd_packet_t                tx_pkt,
  output logic                       tx_pkt_valid,
  input  logic                       tx_pop,
  input  logic                       tx_en,
  output logic [IDW-1:0]             grant_id,
  output logic                       busy,
  output logic                       timeout_err
);

  localparam int WDW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYC - 1);

  arb_state_e         r_state;
  logic [IDW-1:0]     r_rrPtr;
  logic [WDW-1:0]     r_wdog;
  logic               r_seenRise;
  logic [NUM_REQ-1:0] w_gntOnehot;
  logic [IDW-1:0]     w_gntIdx;
  logic               w_gntAny;
  logic               w_wdogExpired;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rrArbiter (
    .req_valid  (req_valid),
    .rr_ptr     (r_rrPtr),
    .gnt_onehot (w_gntOnehot),
    .gnt_idx    (w_gntIdx),
    .gnt_any    (w_gntAny)
  );

  assign req_ready     = (rst_n && r_state == ARB_IDLE) ? w_gntOnehot : '0;
  assign w_wdogExpired = (r_wdog == WD_LAST);

  function automatic logic [IDW-1:0] nextPtr(input logic [IDW-1:0] idx);
    return (int'(idx) == NUM_REQ - 1) ? '0 : idx + 1'b1;
  endfunction

  // The watchdog abort fires on the edge where the count reaches TIMEOUT_CYC,
  // so timeout_err is visible in the following cycle; a pop in that cycle wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ARB_IDLE;
      r_rrPtr      <= '0;
      r_wdog       <= '0;
      r_seenRise   <= 1'b0;
      tx_pkt       <= '0;
      tx_pkt_valid <= 1'b0;
      grant_id     <= '0;
      busy         <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      timeout_err <= 1'b0;
      case (r_state)
        ARB_IDLE: begin
          if (w_gntAny) begin
            tx_pkt       <= req_pkt[w_gntIdx];
            grant_id     <= w_gntIdx;
            r_rrPtr      <= nextPtr(w_gntIdx);
            tx_pkt_valid <= 1'b1;
            busy         <= 1'b1;
            r_wdog       <= '0;
            r_state      <= ARB_PRESENT;
          end
        end
        ARB_PRESENT: begin
          if (tx_pop) begin
            tx_pkt_valid <= 1'b0;
            r_wdog       <= '0;
            r_seenRise   <= tx_en;
            r_state      <= ARB_DRAIN;
          end else if (w_wdogExpired) begin
            timeout_err  <= 1'b1;
            tx_pkt_valid <= 1'b0;
            busy         <= 1'b0;
            r_wdog       <= '0;
            r_state      <= ARB_IDLE;
          end else begin
            r_wdog <= r_wdog + 1'b1;
          end
        end
        ARB_DRAIN: begin
          if (r_seenRise && !tx_en) begin
            busy    <= 1'b0;
            r_wdog  <= '0;
            r_state <= ARB_IDLE;
          end else if (w_wdogExpired) begin
            timeout_err <= 1'b1;
            busy        <= 1'b0;
            r_wdog      <= '0;
            r_state     <= ARB_IDLE;
          end else begin
            if (tx_en) begin
              r_seenRise <= 1'b1;
            end
            r_wdog <= r_wdog + 1'b1;
          end
        end
        default: begin
          r_state <= ARB_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_tx_arb.md
# uart_tx_arb

Round-robin arbiter and sequencer that shares the single `uart_tx` serializer between up to eight response producers (register-read path, error reporter, status/heartbeat, etc.). It accepts one `cmd_packet_t` at a time from the requesters over valid/ready and holds it in a one-entry register presented to `uart_tx` as `cmd_rsp`/`data_ready`. It consumes the `data_read_en` pop, then waits for the frame to finish on the wire before granting again. A watchdog drops packets that are never popped or never finish.

## Interface
- `NUM_REQ`, default 2: number of requesters, legal range 1..8.
- `TIMEOUT_CYC`, default 100000: clk cycles allowed in PRESENT or DRAIN before abort.
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in NUM_REQ: per-requester packet valid.
- `req_pkt` in NUM_REQ x cmd_packet_t: per-requester packet {cmd_type[7:0], addr[7:0], data[7:0]}.
- `req_ready` out NUM_REQ: one-hot accept. Combinational; forced 0 while `rst_n`=0.
- `tx_pkt` out cmd_packet_t: held packet; drives `uart_tx.cmd_rsp`.
- `tx_pkt_valid` out 1: holding register full; drives `uart_tx.data_ready`.
- `tx_pop` in 1: from `uart_tx.data_read_en`; pop of the held packet.
- `tx_en` in 1: from `uart_tx.tx_en`; high while data bits are shifting.
- `grant_id` out $clog2(NUM_REQ) (min 1): index of the requester whose packet is held or draining.
- `busy` out 1: state ≠ IDLE.
- `timeout_err` out 1: one-cycle pulse on watchdog abort.

## Operation
- States: IDLE, PRESENT, DRAIN.
- IDLE
  - If any `req_valid` is set, pick requester g: the first set bit searching upward from `rr_ptr`, wrapping modulo NUM_REQ.
  - Assert `req_ready[g]` only.
  - On that edge: capture `req_pkt[g]` into `tx_pkt`, set `grant_id`←g and `rr_ptr`←(g+1) mod NUM_REQ, then go to PRESENT.
- PRESENT
  - `tx_pkt_valid`=1, and `tx_pkt` is held stable.
  - `tx_pop`=1 → DRAIN, clear `tx_pkt_valid`, clear the watchdog.
- DRAIN
  - Wait for a rising `tx_en`, then its falling edge; on the fall → IDLE.
  - A `tx_en` already high when DRAIN is entered counts as the rise.
- Watchdog
  - Counts clk cycles in PRESENT and DRAIN; restarts on every state change.
  - On reaching TIMEOUT_CYC: pulse `timeout_err`, clear `tx_pkt_valid`, go to IDLE. The packet is dropped and `rr_ptr` is not rolled back.
- Boundary conditions
  - `tx_pop` and timeout in the same cycle: pop wins, no error.
  - `tx_pop` outside PRESENT is ignored, including X/1 after reset.
  - `req_valid` deasserted before grant: nothing happens.
  - A requester holding `req_valid` continuously still yields to the others (fairness).
  - NUM_REQ=1: `rr_ptr` is constant 0.
- Reset values:
  - state=IDLE, `rr_ptr`=0, `tx_pkt`='0.
  - `tx_pkt_valid`=0, `grant_id`=0, `busy`=0, `timeout_err`=0, `req_ready`=0.
  - Watchdog counter=0.
- Reset asserted mid-operation: all of the above apply immediately and the held packet is lost. `uart_tx` shares the reset tree and aborts too.

## Timing
- Grant latency: `req_valid` seen in IDLE cycle N → `req_ready` high in N → `tx_pkt_valid` high in N+1.
- Pop latency: `tx_pop` high in cycle M → `tx_pkt_valid` low in M+1.
- Re-arm: `tx_en` falls in cycle K → IDLE in K+1 → next grant is possible in K+1.
- Back-to-back grants are separated by at least one full frame. No skid buffer and no overlap.
- Watchdog counter width is $clog2(TIMEOUT_CYC+1).
- `timeout_err` is high for exactly the cycle after the count reaches TIMEOUT_CYC.

## Structure
- `uart_pkg` (shared) holds `cmd_packet_t` and `arb_state_e` {ARB_IDLE, ARB_PRESENT, ARB_DRAIN}.
- Sub-module `rr_arbiter`: combinational pick from `req_valid` and `rr_ptr`, producing one-hot and index outputs. Parameterized by NUM_REQ; reusable elsewhere.
- The top level owns the FSM, holding register, `rr_ptr`, and watchdog.

## Test plan
- Single request: req 0 sends {0x02,0x10,0xA5}.
  - `tx_pkt_valid` goes high the next cycle.
  - After a `uart_tx` model pops, the TX line carries bytes 0x02, 0x10, 0xA5 (LSB-first, 8N1).
  - `busy` drops one cycle after `tx_en` falls.
- Contention: NUM_REQ=3 with all `req_valid` held high for six packets → grant order 0,1,2,0,1,2.
- Pop never arrives: with TIMEOUT_CYC=50 and `tx_pop` tied 0, `timeout_err` pulses at 50 cycles after PRESENT entry. Back in IDLE, the next requester is granted.
- Pop and timeout coincide: pulse `tx_pop` on the exact expiry cycle → no `timeout_err`, state moves to DRAIN.
- Reset mid-PRESENT: drop `rst_n` → `tx_pkt_valid`=0, `req_ready`=0, `grant_id`=0 immediately. After release, requester 0 wins first.
- `tx_pop` pulse while in IDLE or DRAIN: no state change, and the packet is not re-popped.
